instruction_executor: RTL and testbench
=======================================

# instruction_executor

Reads instruction words out of the 32-entry instruction register array and executes them in order. The block drives the array's read pointer and captures the combinational instruction word it returns. It then computes the ADD/SUB/MULT/DIV/SL/SR result, honouring the SIGNED/UNSIGNED operand type, and presents each result on a valid/ready handshake. It sits downstream of the instruction register, using the same `definitions_pkg` types (`op_t`, `operand_type_t`, `data_t`, `instruction_t`, `address_t`).

## Interface
- `DEPTH`, 32: number of array entries; the pointer is `address_t` (5 bits) and wraps modulo DEPTH.
- `clk`  in  1: sole clock, all logic on posedge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: begin a run; sampled only in IDLE.
- `start_ptr`  in  5: first entry of the run.
- `count`  in  6: number of instructions in the run, 0..32.
- `read_pointer`  out  5: address driven to the instruction register array.
- `iw`  in  `instruction_t` (69): instruction word at `read_pointer`, combinational.
- `result`  out  64: registered result.
- `result_valid`  out  1: `result` and `error` are valid.
- `result_ready`  in  1: consumer accepts the result.
- `error`  out  1: flag for the current result (illegal opcode or divide by zero).
- `busy`  out  1: high in every state except IDLE.
- `done`  out  1: one-cycle pulse when a run completes.

## Operation
- **Reset values:** every output is 0 and the state is IDLE.
- **IDLE**
  - `start`=1 with `count`≠0: load the pointer from `start_ptr` and `remaining` from `count`, then go to FETCH.
  - `start`=1 with `count`=0: pulse `done` on the next cycle and stay in IDLE.
- **FETCH:** drive `read_pointer` and capture `iw` into an internal register. Go to EXEC.
- **EXEC:** `op_a`/`op_b` are treated as `s_data` when `op_type`=SIGNED and as `u_data` otherwise.
  - ADD and SUB: compute a 33-bit sum/difference. It is sign-extended to 64 bits for SIGNED and zero-extended for UNSIGNED.
  - MULT: full 64-bit product, signed or unsigned.
  - SL: `a << b[4:0]` in `result[31:0]`; upper 32 bits are 0.
  - SR: arithmetic shift for SIGNED, logical for UNSIGNED, by `b[4:0]`; upper 32 bits are 0.
  - Opcodes 6–15: `result`=0, `error`=1.
  - Non-DIV opcodes register `result` and go to HOLD. DIV goes to DIVIDE.
- **DIVIDE:** 32-iteration restoring divider on operand magnitudes.
  - Quotient goes to `result[31:0]`, remainder to `result[63:32]`.
  - SIGNED: the quotient truncates toward zero and the remainder takes the sign of the dividend.
  - `b`=0: quotient=0xFFFFFFFF, remainder=`a`, `error`=1. This is detected in EXEC, but the block still spends the 32 cycles.
  - SIGNED 0x80000000 / 0xFFFFFFFF: quotient=0x80000000, remainder=0, `error`=0.
- **HOLD:** hold `result_valid`=1 with `result`/`error` stable until `result_ready`=1. On that handshake:
  - the pointer increments with wrap (31 → 0) and `remaining` decrements;
  - if `remaining` becomes 0: pulse `done`, go to IDLE, `busy`=0;
  - otherwise go to FETCH.
- `start` while `busy` is ignored.
- A run with `count`=32 visits every entry exactly once.
- `rst` in any state aborts the run. The partial result is discarded and no `done` pulse is issued.

## Timing
- Let edge 0 be the edge that samples `start`. The block is in FETCH during cycle 1, `iw` is captured at edge 1, and EXEC runs in cycle 2.
- Non-DIV ops: `result_valid` rises after edge 2, a latency of 2.
- DIV: DIVIDE runs iterations on edges 3..34 and `result_valid` rises after edge 34, a latency of 34.
- Handshake at edge N: FETCH runs in cycle N+1 and the next non-DIV result is valid after edge N+2. With `result_ready` tied high, peak throughput is one instruction per 3 cycles.
- `done` is high for exactly the one cycle after the final handshake edge.
- `read_pointer` changes only at state edges. The array must not be written at `read_pointer` during FETCH; the block does not check this.

## Configuration
- `EXEC_DIV_EN` defined: the DIVIDE state and divider datapath are compiled in, as specified above.
- `EXEC_DIV_EN` undefined: no divider logic exists. DIV is treated as an illegal opcode: 1-cycle EXEC, `result`=0, `error`=1, DIV latency equals non-DIV latency of 2.

## Test plan
- Run `start_ptr`=3, `count`=2 with entries {ADD, UNSIGNED, 0xFFFFFFFF, 1} and {SUB, SIGNED, 5, 7}, `result_ready`=1 → `result`=0x0000000100000000 then 0xFFFFFFFFFFFFFFFE. Valids appear at latency 2 and 2+3, and `done` pulses once.
- Entries {MULT, SIGNED, -3, 4}, {SR, SIGNED, 0x80000000, 4}, {SL, UNSIGNED, 1, 35} → results 0xFFFFFFFFFFFFFFF4, 0x00000000F8000000, 0x0000000000000008.
- With `EXEC_DIV_EN`:
  - {DIV, SIGNED, -7, 2} → `result`=0xFFFFFFFFFFFFFFFD (remainder −1, quotient −3), latency 34.
  - {DIV, UNSIGNED, 9, 0} → quotient 0xFFFFFFFF, remainder 9, `error`=1.
  - Without the macro, DIV → `result`=0, `error`=1, latency 2.
- `start_ptr`=30, `count`=4 with `result_ready` stalled 5 cycles on each result → `read_pointer` sequence 30, 31, 0, 1. `result` stays stable during each stall, and `start` pulses mid-run are ignored.
- Assert `rst` during DIVIDE and during HOLD → next cycle all outputs are 0 with no `done`. A subsequent `start`, `count`=0, gives `done` on the next cycle with no `result_valid`.

Source files
------------

// File: rtl/definitions_pkg.sv
// definitions_pkg: instruction word types shared by the instruction register and its executor
package definitions_pkg;
    typedef enum logic [3:0] {ADD, SUB, MULT, DIV, SL, SR} op_t;
    typedef enum logic {UNSIGNED, SIGNED} operand_type_t;
    typedef union packed {
        logic signed [31:0] s_data;
        logic        [31:0] u_data;
    } data_t;
    typedef logic [4:0] address_t;
    typedef struct packed {
        op_t           opc;
        operand_type_t op_type;
        data_t         op_a;
        data_t         op_b;
    } instruction_t;
endpackage

// File: rtl/instruction_executor.sv
// instruction_executor: walks the instruction array from start_ptr and executes each word, result on valid/ready; EXEC_DIV_EN adds the 32-cycle divider
module instruction_executor
    import definitions_pkg::*;
#(
    parameter int DEPTH = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  address_t     start_ptr,
    input  logic [5:0]   count,
    output address_t     read_pointer,
    input  instruction_t iw,
    output logic [63:0]  result,
    output logic         result_valid,
    input  logic         result_ready,
    output logic         error,
    output logic         busy,
    output logic         done
);
    typedef enum logic [2:0] {IDLE, FETCH, EXEC, DIVIDE, HOLD} state_t;

    state_t       state, state_next;
    address_t     ptr;
    logic [5:0]   remaining;
    instruction_t ir;
    logic [31:0]  a, b, sra;
    logic         sx, is_div, exec_err;
    logic [32:0]  sum;
    logic [63:0]  ext_a, ext_b, exec_res;

    assign a            = ir.op_a.u_data;
    assign b            = ir.op_b.u_data;
    assign sx           = ir.op_type == SIGNED;
    assign read_pointer = ptr;
    assign busy         = state != IDLE;
    assign result_valid = state == HOLD;

`ifdef EXEC_DIV_EN
    logic [31:0] rem_q, quo_q, rem_n, quo_n, a_mag, d_mag;
    logic [32:0] trial;
    logic [4:0]  iter;
    logic [63:0] div_res;

    assign is_div  = ir.opc == DIV;
    assign a_mag   = (sx & a[31]) ? -a : a;
    assign d_mag   = (sx & b[31]) ? -b : b;
    assign trial   = {rem_q, quo_q[31]} - {1'b0, d_mag};
    assign rem_n   = trial[32] ? {rem_q[30:0], quo_q[31]} : trial[31:0];
    assign quo_n   = {quo_q[30:0], ~trial[32]};
    assign div_res = (b == '0) ? {a, 32'hFFFF_FFFF} :
                     {(sx & a[31]) ? -rem_n : rem_n, (sx & (a[31] ^ b[31])) ? -quo_n : quo_n};
`else
    assign is_div = 1'b0;
`endif

    // single-cycle ALU for every opcode except DIV; ternary arms kept unsigned so SR's arithmetic shift lives in its own signal
    always_comb begin
        ext_a    = {{32{sx & a[31]}}, a};
        ext_b    = {{32{sx & b[31]}}, b};
        sum      = (ir.opc == SUB) ? {sx & a[31], a} - {sx & b[31], b} : {sx & a[31], a} + {sx & b[31], b};
        sra      = $signed(a) >>> b[4:0];
        exec_res = '0;
        exec_err = 1'b0;
        case (ir.opc)
            ADD, SUB: exec_res = {{31{sx & sum[32]}}, sum};
            MULT:     exec_res = ext_a * ext_b;
            SL:       exec_res = {32'b0, a << b[4:0]};
            SR:       exec_res = {32'b0, sx ? sra : a >> b[4:0]};
            default:  exec_err = 1'b1;
        endcase
    end

    // state register
    always_ff @(posedge clk) begin
        state <= rst ? IDLE : state_next;
    end

    // next-state decode
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = (start && count != '0) ? FETCH : IDLE;
            FETCH:   state_next = EXEC;
            EXEC:    state_next = is_div ? DIVIDE : HOLD;
`ifdef EXEC_DIV_EN
            DIVIDE:  state_next = (iter == 5'd31) ? HOLD : DIVIDE;
`endif
            HOLD:    state_next = !result_ready ? HOLD : (remaining == 6'd1) ? IDLE : FETCH;
            default: state_next = IDLE;
        endcase
    end

    // pointer, instruction capture, result and divider datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr       <= '0;
            remaining <= '0;
            ir        <= '0;
            result    <= '0;
            error     <= 1'b0;
            done      <= 1'b0;
`ifdef EXEC_DIV_EN
            rem_q     <= '0;
            quo_q     <= '0;
            iter      <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && count != '0) begin
                        ptr       <= start_ptr;
                        remaining <= count;
                    end else if (start) begin
                        done <= 1'b1;
                    end
                end
                FETCH: ir <= iw;
                EXEC: begin
                    result <= exec_res;
                    error  <= exec_err;
`ifdef EXEC_DIV_EN
                    if (is_div) begin
                        error <= b == '0;
                        rem_q <= '0;
                        quo_q <= a_mag;
                        iter  <= '0;
                    end
`endif
                end
`ifdef EXEC_DIV_EN
                DIVIDE: begin
                    rem_q <= rem_n;
                    quo_q <= quo_n;
                    iter  <= iter + 5'd1;
                    if (iter == 5'd31) result <= div_res;
                end
`endif
                HOLD: begin
                    if (result_ready) begin
                        ptr       <= (ptr == address_t'(DEPTH - 1)) ? '0 : ptr + 5'd1;
                        remaining <= remaining - 6'd1;
                        done      <= remaining == 6'd1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_instruction_executor.sv
// tb_instruction_executor: directed vectors for instruction_executor, DIV expectations follow EXEC_DIV_EN
module tb_instruction_executor;
    import definitions_pkg::*;

    logic         clk = 1'b0, rst = 1'b1, start = 1'b0, result_ready = 1'b0;
    logic [4:0]   start_ptr = '0;
    logic [5:0]   count = '0;
    address_t     read_pointer;
    instruction_t iw;
    logic [63:0]  result;
    logic         result_valid, error, busy, done;

    instruction_t mem [32];
    int           n_vec = 0, n_bad = 0, done_total = 0;
    logic [63:0]  r_res [32];
    logic         r_err [32];
    int           r_lat [32];
    logic [4:0]   r_ptr [32];
    logic [63:0]  eb [10];
    logic         ebe [10];
    int           ebl [10];

    instruction_executor dut (
        .clk(clk), .rst(rst), .start(start), .start_ptr(start_ptr), .count(count),
        .read_pointer(read_pointer), .iw(iw), .result(result), .result_valid(result_valid),
        .result_ready(result_ready), .error(error), .busy(busy), .done(done)
    );

    assign iw = mem[read_pointer];

    // free-running clock
    always #5 clk = ~clk;

    // count every cycle done is observed high
    always @(negedge clk) if (done) done_total++;

    function automatic instruction_t mk(input op_t o, input operand_type_t ty, input logic [31:0] x, input logic [31:0] y);
        instruction_t w;
        w.opc = o;
        w.op_type = ty;
        w.op_a.u_data = x;
        w.op_b.u_data = y;
        return w;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic run(input logic [4:0] sp, input logic [5:0] n, input int stall);
        int t, hs, d0;
        t = 0;
        hs = 0;
        d0 = done_total;
        result_ready = (stall == 0);
        start = 1'b1;
        start_ptr = sp;
        count = n;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < int'(n); i++) begin
            while (!result_valid && t < 400) begin
                @(negedge clk);
                t++;
            end
            check("valid", result_valid, 1);
            r_res[i] = result;
            r_err[i] = error;
            r_lat[i] = t - hs;
            r_ptr[i] = read_pointer;
            for (int k = 0; k < stall; k++) begin
                start = (k == 1);
                start_ptr = 5'd9;
                @(negedge clk);
                t++;
                check("hold_res", result, r_res[i]);
                check("hold_vld", result_valid, 1);
            end
            start = 1'b0;
            result_ready = 1'b1;
            hs = t + 1;
            @(negedge clk);
            t++;
            result_ready = (stall == 0);
        end
        check("done_pulse", done, 1);
        repeat (2) @(negedge clk);
        check("done_cnt", done_total - d0, 1);
        check("idle_busy", busy, 0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = mk(ADD, UNSIGNED, 0, 0);
        mem[3]  = mk(ADD, UNSIGNED, 32'hFFFF_FFFF, 1);
        mem[4]  = mk(SUB, SIGNED, 5, 7);
        mem[10] = mk(MULT, SIGNED, -32'sd3, 4);
        mem[11] = mk(SR, SIGNED, 32'h8000_0000, 4);
        mem[12] = mk(SL, UNSIGNED, 1, 35);
        mem[13] = mk(op_t'(4'd9), UNSIGNED, 1, 1);
        mem[14] = mk(DIV, SIGNED, -32'sd7, 2);
        mem[15] = mk(DIV, UNSIGNED, 9, 0);
        mem[16] = mk(DIV, SIGNED, 32'h8000_0000, 32'hFFFF_FFFF);
        mem[17] = mk(SR, UNSIGNED, 32'h8000_0000, 4);
        mem[18] = mk(SUB, UNSIGNED, 0, 1);
        mem[19] = mk(ADD, SIGNED, 32'h7FFF_FFFF, 1);
        mem[30] = mk(ADD, UNSIGNED, 1, 2);
        mem[31] = mk(SUB, UNSIGNED, 10, 3);
        mem[0]  = mk(MULT, UNSIGNED, 6, 7);
        mem[1]  = mk(SL, UNSIGNED, 3, 4);
        eb  = '{64'hFFFF_FFFF_FFFF_FFF4, 64'h0000_0000_F800_0000, 64'h8, 64'h0,
                64'h0, 64'h0, 64'h0, 64'h0000_0000_0800_0000, 64'h0000_0001_FFFF_FFFF, 64'h0000_0000_8000_0000};
        ebe = '{0, 0, 0, 1, 1, 1, 1, 0, 0, 0};
        ebl = '{2, 2, 2, 2, 2, 2, 2, 2, 2, 2};
`ifdef EXEC_DIV_EN
        eb[4] = 64'hFFFF_FFFF_FFFF_FFFD;  ebe[4] = 1'b0; ebl[4] = 34;
        eb[5] = 64'h0000_0009_FFFF_FFFF;  ebe[5] = 1'b1; ebl[5] = 34;
        eb[6] = 64'h0000_0000_8000_0000;  ebe[6] = 1'b0; ebl[6] = 34;
`endif
        repeat (3) @(negedge clk);
        check("rst_result", result, 0);
        check("rst_valid", result_valid, 0);
        check("rst_error", error, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ptr", read_pointer, 0);
        rst = 1'b0;
        @(negedge clk);

        run(5'd3, 6'd2, 0);
        check("A0_res", r_res[0], 64'h0000_0001_0000_0000);
        check("A1_res", r_res[1], 64'hFFFF_FFFF_FFFF_FFFE);
        check("A0_err", r_err[0], 0);
        check("A1_err", r_err[1], 0);
        check("A0_lat", r_lat[0], 2);
        check("A1_lat", r_lat[1], 2);
        check("A1_ptr", r_ptr[1], 4);

        run(5'd10, 6'd10, 0);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("B%0d_res", i), r_res[i], eb[i]);
            check($sformatf("B%0d_err", i), r_err[i], ebe[i]);
            check($sformatf("B%0d_lat", i), r_lat[i], ebl[i]);
        end

        run(5'd30, 6'd4, 5);
        check("D0_ptr", r_ptr[0], 30);
        check("D1_ptr", r_ptr[1], 31);
        check("D2_ptr", r_ptr[2], 0);
        check("D3_ptr", r_ptr[3], 1);
        check("D0_res", r_res[0], 3);
        check("D1_res", r_res[1], 7);
        check("D2_res", r_res[2], 42);
        check("D3_res", r_res[3], 48);

        begin
            int d0;
            result_ready = 1'b0;
            start = 1'b1;
            start_ptr = 5'd14;
            count = 6'd1;
            @(negedge clk);
            start = 1'b0;
            repeat (6) @(negedge clk);
            d0 = done_total;
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            check("abort1_result", result, 0);
            check("abort1_valid", result_valid, 0);
            check("abort1_error", error, 0);
            check("abort1_busy", busy, 0);
            check("abort1_done", done, 0);
            check("abort1_ptr", read_pointer, 0);
            repeat (3) @(negedge clk);
            check("abort1_nodone", done_total - d0, 0);

            start = 1'b1;
            start_ptr = 5'd3;
            count = 6'd2;
            @(negedge clk);
            start = 1'b0;
            for (int t = 0; t < 10 && !result_valid; t++) @(negedge clk);
            check("abort2_hold", result_valid, 1);
            d0 = done_total;
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            check("abort2_result", result, 0);
            check("abort2_valid", result_valid, 0);
            check("abort2_busy", busy, 0);
            check("abort2_ptr", read_pointer, 0);
            repeat (3) @(negedge clk);
            check("abort2_nodone", done_total - d0, 0);

            start = 1'b1;
            count = 6'd0;
            @(negedge clk);
            start = 1'b0;
            check("zero_done", done, 1);
            check("zero_valid", result_valid, 0);
            check("zero_busy", busy, 0);
            @(negedge clk);
            check("zero_done_end", done, 0);
            check("zero_valid_end", result_valid, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
